// File: rtl/fb_port_arbiter.sv
// Single-port video buffer arbiter: VGA reads always win, capture writes are
// queued in a small FIFO and drained into idle buffer cycles.
module fb_port_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MEM_LAT    = 1
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [18:0] wr_addr,
  input  logic [15:0] wr_data,
  input  logic        rd_en,
  input  logic [18:0] rd_addr,
  output logic [15:0] rd_data,
  output logic        rd_dv,
  output logic        mem_en,
  output logic        mem_we,
  output logic [18:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic [4:0]  fifo_level,
  output logic [15:0] stall_cnt
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_READ,
    GNT_WRITE
  } grant_e;

  grant_e         w_grant;
  logic           w_push;
  logic           w_pop;
  logic           w_ready;

  logic [18:0]    r_fq_addr [FIFO_DEPTH];
  logic [15:0]    r_fq_data [FIFO_DEPTH];
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [4:0]     r_level;
  logic [15:0]    r_stall;

  logic           r_mem_en;
  logic           r_mem_we;
  logic [18:0]    r_mem_addr;
  logic [15:0]    r_mem_wdata;

  logic [MEM_LAT:0] r_rd_pipe;
  logic           r_rd_dv;
  logic [15:0]    r_rd_data;

  // Full FIFO refuses even when the head is popping this cycle.
  assign w_ready = !rst && (r_level < 5'(FIFO_DEPTH));
  assign w_push  = wr_valid && w_ready;
  assign w_pop   = (w_grant == GNT_WRITE);

  always_comb begin
    w_grant = GNT_IDLE;
    if (rd_en) begin
      w_grant = GNT_READ;
    end else if (r_level != '0) begin
      w_grant = GNT_WRITE;
    end
  end

  always_ff @(posedge pclk) begin
    if (w_push) begin
      r_fq_addr[r_wptr] <= wr_addr;
      r_fq_data[r_wptr] <= wr_data;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_stall     <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rd_pipe   <= '0;
      r_rd_dv     <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 5'd1;
        2'b01:   r_level <= r_level - 5'd1;
        default: r_level <= r_level;
      endcase

      if (wr_valid && !w_ready && (r_stall != '1)) begin
        r_stall <= r_stall + 16'd1;
      end

      case (w_grant)
        GNT_READ: begin
          r_mem_en   <= 1'b1;
          r_mem_we   <= 1'b0;
          r_mem_addr <= rd_addr;
        end
        GNT_WRITE: begin
          r_mem_en    <= 1'b1;
          r_mem_we    <= 1'b1;
          r_mem_addr  <= r_fq_addr[r_rptr];
          r_mem_wdata <= r_fq_data[r_rptr];
        end
        default: begin
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
        end
      endcase

      // Stage MEM_LAT lines up with mem_rdata for the read issued MEM_LAT+1 cycles ago.
      r_rd_pipe <= {r_rd_pipe[MEM_LAT-1:0], rd_en};
      r_rd_dv   <= r_rd_pipe[MEM_LAT];
      if (r_rd_pipe[MEM_LAT]) begin
        r_rd_data <= mem_rdata;
      end
    end
  end

  assign wr_ready   = w_ready;
  assign rd_data    = r_rd_data;
  assign rd_dv      = r_rd_dv;
  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign fifo_level = r_level;
  assign stall_cnt  = r_stall;

endmodule
